vga_sprite_engine: RTL and testbench
====================================

# vga_sprite_engine

Parametrised VGA timing generator and pixel renderer for the game display. Produces standard sync pulses from generic porch/sync parameters and composites a configurable number of rectangular sprites over a programmable banded background and optional grid. Sprite state is shadowed once per frame for tear-free motion. Player-to-sprite overlap is reported as per-frame collision flags. Sits between the game-logic blocks, which supply positions, and the board VGA pins.

## Interface

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- NUM_SPRITES, 4, sprite channels (2..8); channel 0 is the player
- SPRITE_W, 32, sprite width in pixels
- SPRITE_H, 32, sprite height in pixels
- GRID_W, 32, grid cell width
- GRID_H, 32, grid cell height; V_ACTIVE/GRID_H ≤ 16

Ports:
- clk  in  1  pixel clock
- rstN  in  1  asynchronous active-low reset
- spriteX  in  10*NUM_SPRITES  X positions; channel k in bits [10k+9:10k]
- spriteY  in  10*NUM_SPRITES  Y positions, same packing
- spriteEn  in  NUM_SPRITES  per-channel enable
- spriteColor  in  9*NUM_SPRITES  {R,G,B} 3 bits each per channel
- bandMask  in  16  bit r set → grid row r painted gray
- gridEn  in  1  draw grid lines
- vgaR, vgaG, vgaB  out  3 each  pixel colour
- vgaHs, vgaVs  out  1 each  syncs, active-low
- frameStart  out  1  one-clock pulse at shadow-load point
- collision  out  NUM_SPRITES-1  bit k-1: player overlapped sprite k during last frame

## Operation

- Counters hCount/vCount, 10 bits, H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP ≤ 1024, same for V. Line order: active, front porch, sync, back porch. hCount wraps at H_TOTAL-1; vCount increments on hCount wrap and wraps at V_TOTAL-1.
- Hs low while H_ACTIVE+H_FP ≤ hCount < H_ACTIVE+H_FP+H_SYNC; Vs likewise on vCount.
- Shadow load: in the cycle with hCount==0 and vCount==V_ACTIVE (first blanking line), all sprite inputs are copied to shadow registers. frameStart is asserted for that same cycle, registered. Rendering uses shadow values only; input changes mid-frame have no visible effect.
- Sprite hit k: shadowEn[k], and px ∈ [X, X+SPRITE_W), and py ∈ [Y, Y+SPRITE_H). Compare at 11 bits so X+W never wraps. Sprites at X ≥ H_ACTIVE are clipped, not wrapped.
- Pixel priority, highest first:
  - lowest-index hit sprite, in its shadow colour;
  - gray (3'b100 each) if bandMask[py/GRID_H];
  - gray if gridEn and (px%GRID_W==0 or py%GRID_H==0);
  - black.
- Outside the active area, RGB is forced to 0.
- Collision: in the active area, accumulator bit k-1 is set when hit 0 and hit k are both true on the same pixel. At the shadow-load cycle, collision ← accumulator and the accumulator clears. If a hit and the clear fall in the same cycle, clear wins. The load point is in blanking, so no active pixel can coincide with it.

## Timing

- Stage 0: counters. Stage 1: register active flag, px/py, hit vector, band and grid bits, raw Hs/Vs. Stage 2: priority mux into vgaR/G/B with Hs/Vs.
- RGB and syncs are both exactly 2 clocks behind their counter values, so they stay mutually aligned.
- frameStart and collision update 1 clock after the load-point counter value.
- Reset, asynchronous: counters 0, all pipeline registers 0, vgaR/G/B 0, vgaHs/vgaVs 1, frameStart 0, collision 0, shadows 0 (all sprites disabled).
- First frame after reset renders background only until the first shadow load.
- Reset asserted mid-line returns all outputs to their reset values immediately; the counters restart at 0,0 on release.

## Test plan

- Reset release, defaults → vgaHs first low 658 clocks after release (hCount 656 + 2 stages), width 96; vgaVs low for 2 lines starting at line 490; frame period 800×525 clocks.
- Sprite 1 at (100,200), colour 9'o700, enabled, loaded before frame → pixels (100..131, 200..231) red, (132,200) background; RGB edge coincides with expected counter+2.
- Sprites 0 and 1 both at (50,50), distinct colours → sprite 0 colour wins; after the next frameStart, collision == 3'b001; next frame with sprite 0 moved away → collision == 0.
- spriteX changed mid-frame (line 240) → no change in the current frame; new position appears only after the next frameStart.
- bandMask=16'h0001, gridEn=0 → lines 0..31 gray, rest black; gridEn=1 → column 32 and line 64 gray.
- Sprite at X=630 → columns 630..639 drawn, nothing wraps to column 0; sprite at X=1000 invisible.

Source files
------------

// File: rtl/vga_sprite_engine_if.sv
// Bus between the game-logic blocks and the sprite engine: sprite positions,
// colours and background controls in, VGA pins, frame pulse and collision flags out.
interface vga_sprite_engine_if #(
   parameter int NUM_SPRITES = 4
);
   logic [10*NUM_SPRITES-1:0] spriteX;
   logic [10*NUM_SPRITES-1:0] spriteY;
   logic [NUM_SPRITES-1:0]    spriteEn;
   logic [9*NUM_SPRITES-1:0]  spriteColor;
   logic [15:0]               bandMask;
   logic                      gridEn;
   logic [2:0]                vgaR;
   logic [2:0]                vgaG;
   logic [2:0]                vgaB;
   logic                      vgaHs;
   logic                      vgaVs;
   logic                      frameStart;
   logic [NUM_SPRITES-2:0]    collision;

   // Game side: supplies sprite state, observes the display outputs.
   modport master (
      output spriteX, spriteY, spriteEn, spriteColor, bandMask, gridEn,
      input  vgaR, vgaG, vgaB, vgaHs, vgaVs, frameStart, collision
   );

   // Engine side.
   modport slave (
      input  spriteX, spriteY, spriteEn, spriteColor, bandMask, gridEn,
      output vgaR, vgaG, vgaB, vgaHs, vgaVs, frameStart, collision
   );
endinterface

// File: rtl/vga_sprite_engine.sv
// VGA timing generator and sprite compositor. Counters (stage 0) feed a
// registered decode stage (stage 1) and a registered priority mux (stage 2),
// so pixels and syncs leave exactly two clocks after their counter values.
// Sprite state is shadowed once per frame on the first blanking line.
module vga_sprite_engine #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int NUM_SPRITES = 4,
   parameter int SPRITE_W    = 32,
   parameter int SPRITE_H    = 32,
   parameter int GRID_W      = 32,
   parameter int GRID_H      = 32
) (
   input  logic               clk,
   input  logic               rstN,
   vga_sprite_engine_if.slave bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_ACT_C  = 10'(H_ACTIVE);
   localparam logic [9:0]  V_ACT_C  = 10'(V_ACTIVE);
   localparam logic [9:0]  HS_BEG   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] SPR_W_C  = 11'(SPRITE_W);
   localparam logic [10:0] SPR_H_C  = 11'(SPRITE_H);
   localparam logic [9:0]  GRID_W_C = 10'(GRID_W);
   localparam logic [9:0]  GRID_H_C = 10'(GRID_H);
   localparam logic [8:0]  GRAY     = 9'b100_100_100;

   logic [9:0]                h_cnt_r, v_cnt_r;
   logic                      h_wrap_s, load_s;
   logic [10*NUM_SPRITES-1:0] shd_x_r, shd_y_r;
   logic [NUM_SPRITES-1:0]    shd_en_r;
   logic [9*NUM_SPRITES-1:0]  shd_color_r;
   logic [NUM_SPRITES-1:0]    hit_s, hit_r;
   logic                      act_s, act_r, band_s, band_r, grid_s, grid_r;
   logic                      hsync_s, hsync_r, vsync_s, vsync_r;
   logic [9:0]                row_s;
   logic [8:0]                spr_rgb_s, rgb_s, rgb_r;
   logic                      hs_r, vs_r, frame_start_r;
   logic [NUM_SPRITES-2:0]    acc_set_s, acc_r, coll_r;

   assign h_wrap_s = (h_cnt_r == H_LAST);
   // First clock of the first blanking line: the single shadow-load point.
   assign load_s   = (h_cnt_r == 10'd0) && (v_cnt_r == V_ACT_C);

   // Stage 0: raster counters, horizontal then vertical.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         h_cnt_r <= 10'd0;
         v_cnt_r <= 10'd0;
      end else if (h_wrap_s) begin
         h_cnt_r <= 10'd0;
         v_cnt_r <= (v_cnt_r == V_LAST) ? 10'd0 : v_cnt_r + 10'd1;
      end else begin
         h_cnt_r <= h_cnt_r + 10'd1;
      end
   end

   // Sprite shadow registers, reloaded once per frame for tear-free motion.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         shd_x_r     <= '0;
         shd_y_r     <= '0;
         shd_en_r    <= '0;
         shd_color_r <= '0;
      end else if (load_s) begin
         shd_x_r     <= bus.spriteX;
         shd_y_r     <= bus.spriteY;
         shd_en_r    <= bus.spriteEn;
         shd_color_r <= bus.spriteColor;
      end
   end

   // Stage 0 decode: active area, sync windows, band/grid and per-sprite hits.
   // Hit bounds use 11 bits so X+W cannot wrap back into the visible area.
   always_comb begin
      act_s   = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
      hsync_s = (h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END);
      vsync_s = (v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END);
      row_s   = v_cnt_r / GRID_H_C;
      band_s  = (row_s < 10'd16) ? bus.bandMask[row_s[3:0]] : 1'b0;
      grid_s  = bus.gridEn && (((h_cnt_r % GRID_W_C) == 10'd0) ||
                               ((v_cnt_r % GRID_H_C) == 10'd0));
      hit_s   = '0;
      for (int k = 0; k < NUM_SPRITES; k++) begin
         hit_s[k] = shd_en_r[k] &&
            ({1'b0, h_cnt_r} >= {1'b0, shd_x_r[10*k +: 10]}) &&
            ({1'b0, h_cnt_r} <  ({1'b0, shd_x_r[10*k +: 10]} + SPR_W_C)) &&
            ({1'b0, v_cnt_r} >= {1'b0, shd_y_r[10*k +: 10]}) &&
            ({1'b0, v_cnt_r} <  ({1'b0, shd_y_r[10*k +: 10]} + SPR_H_C));
      end
   end

   // Stage 1 registers; raw syncs held active-high so reset means "not in sync".
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         act_r   <= 1'b0;
         hit_r   <= '0;
         band_r  <= 1'b0;
         grid_r  <= 1'b0;
         hsync_r <= 1'b0;
         vsync_r <= 1'b0;
      end else begin
         act_r   <= act_s;
         hit_r   <= hit_s;
         band_r  <= band_s;
         grid_r  <= grid_s;
         hsync_r <= hsync_s;
         vsync_r <= vsync_s;
      end
   end

   // Stage 2 priority mux: lowest sprite index wins, then band, grid, black.
   always_comb begin
      spr_rgb_s = 9'd0;
      for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
         spr_rgb_s = hit_r[k] ? shd_color_r[9*k +: 9] : spr_rgb_s;
      end
      if (!act_r) begin
         rgb_s = 9'd0;
      end else if (hit_r != '0) begin
         rgb_s = spr_rgb_s;
      end else if (band_r || grid_r) begin
         rgb_s = GRAY;
      end else begin
         rgb_s = 9'd0;
      end
      acc_set_s = '0;
      for (int k = 1; k < NUM_SPRITES; k++) begin
         acc_set_s[k-1] = act_r && hit_r[0] && hit_r[k];
      end
   end

   // Stage 2 output registers: pixel colour and active-low syncs.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         rgb_r <= 9'd0;
         hs_r  <= 1'b1;
         vs_r  <= 1'b1;
      end else begin
         rgb_r <= rgb_s;
         hs_r  <= ~hsync_r;
         vs_r  <= ~vsync_r;
      end
   end

   // Collision accumulator; the load point publishes and clears it (clear wins).
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         acc_r         <= '0;
         coll_r        <= '0;
         frame_start_r <= 1'b0;
      end else begin
         frame_start_r <= load_s;
         if (load_s) begin
            coll_r <= acc_r;
            acc_r  <= '0;
         end else begin
            acc_r  <= acc_r | acc_set_s;
         end
      end
   end

   assign bus.vgaR       = rgb_r[8:6];
   assign bus.vgaG       = rgb_r[5:3];
   assign bus.vgaB       = rgb_r[2:0];
   assign bus.vgaHs      = hs_r;
   assign bus.vgaVs      = vs_r;
   assign bus.frameStart = frame_start_r;
   assign bus.collision  = coll_r;
endmodule

// File: tb/tb_vga_sprite_engine.sv
// Self-checking bench for vga_sprite_engine on a shrunken raster (56x37 clocks
// per frame). A monitor compares every output against a frame-level reference
// model; a vector table, a mid-frame update and a mid-line reset add targeted checks.
module tb_vga_sprite_engine;
   localparam int H_ACT = 48, H_FP = 2, H_SY = 4, H_BP = 2;
   localparam int V_ACT = 32, V_FP = 1, V_SY = 2, V_BP = 2;
   localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
   localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
   localparam int FRAME = H_TOT * V_TOT;
   localparam int LOAD_IDX = V_ACT * H_TOT;
   localparam int NS = 4, SW = 8, SH = 8, GW = 8, GH = 8;
   localparam logic [8:0] GRAY = 9'o444;

   typedef struct {
      logic [39:0] sx;
      logic [39:0] sy;
      logic [3:0]  en;
      logic [35:0] col;
      logic [15:0] band;
      logic        grid;
      int          p0x, p0y;
      logic [8:0]  p0c;
      int          p1x, p1y;
      logic [8:0]  p1c;
      logic [2:0]  coll;
   } vec_t;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   cur_v = -1;

   logic [39:0] m_sx, m_sy;
   logic [3:0]  m_en;
   logic [35:0] m_col;
   logic [2:0]  m_acc, m_coll;
   logic [8:0]  obs [V_ACT][H_ACT];
   vec_t        tbl [7];

   vga_sprite_engine_if #(.NUM_SPRITES(NS)) bus ();

   vga_sprite_engine #(
      .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
      .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
      .NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH), .GRID_W(GW), .GRID_H(GH)
   ) dut (
      .clk(clk),
      .rstN(rstN),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: does shadowed sprite k cover pixel (h,v)?
   function automatic bit covers(int k, int h, int v);
      int x, y;
      x = int'(m_sx[10*k +: 10]);
      y = int'(m_sy[10*k +: 10]);
      return m_en[k] && h >= x && h < x + SW && v >= y && v < y + SH;
   endfunction

   function automatic logic [8:0] model_rgb(int h, int v);
      if (h >= H_ACT || v >= V_ACT) return 9'd0;
      for (int k = 0; k < NS; k++)
         if (covers(k, h, v)) return m_col[9*k +: 9];
      if (v / GH < 16 && bus.bandMask[v / GH]) return GRAY;
      if (bus.gridEn && (h % GW == 0 || v % GH == 0)) return GRAY;
      return 9'd0;
   endfunction

   // Monitor: per-clock reference model and comparison of every output.
   always @(posedge clk) begin
      int p, h, v;
      logic [8:0] e_rgb;
      logic e_hs, e_vs, e_fs;
      #1;
      if (!rstN) begin
         cyc = 0;
         m_sx = '0; m_sy = '0; m_en = '0; m_col = '0;
         m_acc = '0; m_coll = '0;
         check("reset_out", {bus.vgaR, bus.vgaG, bus.vgaB, bus.vgaHs, bus.vgaVs,
                             bus.frameStart, bus.collision},
               {9'd0, 1'b1, 1'b1, 1'b0, 3'd0});
      end else begin
         cyc++;
         e_fs = 1'b0;
         if ((cyc - 1) % FRAME == LOAD_IDX) begin
            m_sx = bus.spriteX; m_sy = bus.spriteY;
            m_en = bus.spriteEn; m_col = bus.spriteColor;
            m_coll = m_acc; m_acc = '0; e_fs = 1'b1;
         end
         p = cyc - 2;
         if (p < 0) begin
            e_rgb = 9'd0; e_hs = 1'b1; e_vs = 1'b1;
         end else begin
            h = p % H_TOT;
            v = (p / H_TOT) % V_TOT;
            cur_v = v;
            e_rgb = model_rgb(h, v);
            e_hs = !(h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SY);
            e_vs = !(v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SY);
            if (h < H_ACT && v < V_ACT) begin
               obs[v][h] = {bus.vgaR, bus.vgaG, bus.vgaB};
               for (int k = 1; k < NS; k++)
                  if (covers(0, h, v) && covers(k, h, v)) m_acc[k-1] = 1'b1;
            end
         end
         check("pixel", {bus.vgaR, bus.vgaG, bus.vgaB, bus.vgaHs, bus.vgaVs},
               {e_rgb, e_hs, e_vs});
         check("frameStart", bus.frameStart, e_fs);
         check("collision", bus.collision, m_coll);
      end
   end

   task automatic drive(input logic [39:0] sx, input logic [39:0] sy, input logic [3:0] en,
                        input logic [35:0] col, input logic [15:0] band, input logic grid);
      @(negedge clk);
      bus.spriteX = sx; bus.spriteY = sy; bus.spriteEn = en;
      bus.spriteColor = col; bus.bandMask = band; bus.gridEn = grid;
   endtask

   task automatic wait_load();
      for (int i = 0; i < FRAME + 16; i++) begin
         @(posedge clk); #2;
         if (bus.frameStart === 1'b1) return;
      end
      check("load_timeout", 32'd1, 32'd0);
   endtask

   // Sync timing measured from reset release (cyc counts edges since release).
   task automatic sync_timing(input bit full);
      int t0, w, tv0, tv1;
      t0 = -1; w = 0; tv0 = -1; tv1 = -1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #2;
         if (bus.vgaHs === 1'b0) begin t0 = cyc; break; end
      end
      check("hs_first_low", t0, H_ACT + H_FP + 2);
      for (int i = 0; i < 200; i++) begin
         if (bus.vgaHs !== 1'b0) break;
         w++; @(posedge clk); #2;
      end
      check("hs_width", w, H_SY);
      if (full) begin
         for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk); #2;
            if (bus.vgaVs === 1'b0) begin tv0 = cyc; break; end
         end
         check("vs_first_low", tv0, (V_ACT + V_FP) * H_TOT + 2);
         w = 0;
         for (int i = 0; i < 2 * FRAME; i++) begin
            if (bus.vgaVs !== 1'b0) break;
            w++; @(posedge clk); #2;
         end
         check("vs_width", w, V_SY * H_TOT);
         for (int i = 0; i < 2 * FRAME; i++) begin
            @(posedge clk); #2;
            if (bus.vgaVs === 1'b0) begin tv1 = cyc; break; end
         end
         check("frame_period", tv1 - tv0, FRAME);
      end
   endtask

   initial begin
      logic [39:0] rx, ry;
      logic [35:0] rc;
      tbl[0] = '{{10'd0, 10'd0, 10'd10, 10'd0}, {10'd0, 10'd0, 10'd12, 10'd0}, 4'b0010,
                 {9'o0, 9'o0, 9'o700, 9'o0}, 16'h0000, 1'b0,
                 10, 12, 9'o700, 18, 12, 9'o000, 3'b000};
      tbl[1] = '{{10'd0, 10'd0, 10'd20, 10'd20}, {10'd0, 10'd0, 10'd16, 10'd16}, 4'b0011,
                 {9'o0, 9'o0, 9'o700, 9'o070}, 16'h0000, 1'b0,
                 20, 16, 9'o070, 27, 23, 9'o070, 3'b001};
      tbl[2] = '{{10'd0, 10'd0, 10'd20, 10'd0}, {10'd0, 10'd0, 10'd16, 10'd0}, 4'b0011,
                 {9'o0, 9'o0, 9'o700, 9'o070}, 16'h0000, 1'b0,
                 20, 16, 9'o700, 7, 7, 9'o070, 3'b000};
      tbl[3] = '{40'd0, 40'd0, 4'b0000, 36'd0, 16'h0001, 1'b0,
                 5, 7, GRAY, 5, 8, 9'o000, 3'b000};
      tbl[4] = '{40'd0, 40'd0, 4'b0000, 36'd0, 16'h0000, 1'b1,
                 16, 3, GRAY, 3, 5, 9'o000, 3'b000};
      tbl[5] = '{{10'd1000, 10'd44, 10'd0, 10'd0}, {10'd0, 10'd4, 10'd0, 10'd0}, 4'b1100,
                 {9'o777, 9'o007, 9'o0, 9'o0}, 16'h0000, 1'b0,
                 47, 4, 9'o007, 0, 4, 9'o000, 3'b000};
      tbl[6] = '{{10'd40, 10'd0, 10'd0, 10'd44}, {10'd28, 10'd0, 10'd0, 10'd24}, 4'b1001,
                 {9'o707, 9'o0, 9'o0, 9'o070}, 16'h0000, 1'b0,
                 44, 24, 9'o070, 40, 28, 9'o707, 3'b100};

      bus.spriteX = '0; bus.spriteY = '0; bus.spriteEn = '0;
      bus.spriteColor = '0; bus.bandMask = '0; bus.gridEn = 1'b0;
      repeat (4) @(negedge clk);
      rstN = 1'b1;
      sync_timing(1'b1);

      // Table-driven frames: load, render one frame, then inspect it.
      wait_load();
      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].sx, tbl[i].sy, tbl[i].en, tbl[i].col, tbl[i].band, tbl[i].grid);
         wait_load();
         wait_load();
         check($sformatf("vec%0d_probe0", i), obs[tbl[i].p0y][tbl[i].p0x], tbl[i].p0c);
         check($sformatf("vec%0d_probe1", i), obs[tbl[i].p1y][tbl[i].p1x], tbl[i].p1c);
         check($sformatf("vec%0d_coll", i), bus.collision, tbl[i].coll);
      end

      // Mid-frame position change must wait for the next shadow load.
      drive({10'd0, 10'd0, 10'd10, 10'd0}, {10'd0, 10'd0, 10'd10, 10'd0}, 4'b0010,
            {9'o0, 9'o0, 9'o700, 9'o0}, 16'h0000, 1'b0);
      wait_load();
      for (int i = 0; i < FRAME; i++) begin
         @(posedge clk); #2;
         if (cur_v == 16) break;
      end
      check("midframe_reach_line", cur_v, 16);
      @(negedge clk);
      bus.spriteX = {10'd0, 10'd0, 10'd30, 10'd0};
      wait_load();
      check("midframe_old_pos", obs[10][10], 9'o700);
      check("midframe_new_absent", obs[10][30], 9'o000);
      wait_load();
      check("nextframe_new_pos", obs[10][30], 9'o700);
      check("nextframe_old_gone", obs[10][10], 9'o000);

      // Random frames, checked every clock by the monitor model.
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < NS; k++) begin
            rx[10*k +: 10] = 10'($urandom_range(0, 55));
            ry[10*k +: 10] = 10'($urandom_range(0, 38));
            rc[9*k +: 9]   = 9'($urandom_range(1, 511));
         end
         drive(rx, ry, 4'($urandom_range(0, 15)), rc, 16'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)));
         wait_load();
         wait_load();
      end

      // Reset in the middle of a line, during horizontal sync with collision set.
      drive(tbl[6].sx, tbl[6].sy, tbl[6].en, tbl[6].col, 16'h0000, 1'b0);
      wait_load();
      wait_load();
      check("pre_reset_coll", bus.collision, 3'b100);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #2;
         if (bus.vgaHs === 1'b0) break;
      end
      @(negedge clk); #2;
      rstN = 1'b0;
      #1;
      check("reset_immediate", {bus.vgaR, bus.vgaG, bus.vgaB, bus.vgaHs, bus.vgaVs,
                                bus.frameStart, bus.collision},
            {9'd0, 1'b1, 1'b1, 1'b0, 3'd0});
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      sync_timing(1'b0);
      wait_load();
      repeat (10) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
